// File: rtl/seg7_pkg.sv
// seg7_pkg: segment codes, scan states and inverse segment decode for the 7-segment bus monitor
package seg7_pkg;
    typedef logic [0:6] seg7_code_t;
    localparam seg7_code_t SEG_0 = 7'b0000001;
    localparam seg7_code_t SEG_1 = 7'b1001111;
    localparam seg7_code_t SEG_2 = 7'b0010010;
    localparam seg7_code_t SEG_3 = 7'b0000110;
    localparam seg7_code_t SEG_4 = 7'b1001100;
    localparam seg7_code_t SEG_5 = 7'b0100100;
    localparam seg7_code_t SEG_6 = 7'b0100000;
    localparam seg7_code_t SEG_7 = 7'b0001111;
    localparam seg7_code_t SEG_8 = 7'b0000000;
    localparam seg7_code_t SEG_9 = 7'b0001100;
    localparam seg7_code_t SEG_A = 7'b0001000;
    localparam seg7_code_t SEG_B = 7'b1100000;
    localparam seg7_code_t SEG_C = 7'b0110001;
    localparam seg7_code_t SEG_D = 7'b1000010;
    localparam seg7_code_t SEG_E = 7'b0110000;
    localparam seg7_code_t SEG_F = 7'b0111000;
    localparam seg7_code_t SEG_BLANK = 7'b1111111;
    typedef enum logic [1:0] {IDLE, TRACK, CAPTURED} scan_state_t;
    function automatic logic [4:0] seg7_to_nibble(input seg7_code_t code);
        case (code)
            SEG_0: return 5'h10;
            SEG_1: return 5'h11;
            SEG_2: return 5'h12;
            SEG_3: return 5'h13;
            SEG_4: return 5'h14;
            SEG_5: return 5'h15;
            SEG_6: return 5'h16;
            SEG_7: return 5'h17;
            SEG_8: return 5'h18;
            SEG_9: return 5'h19;
            SEG_A: return 5'h1A;
            SEG_B: return 5'h1B;
            SEG_C: return 5'h1C;
            SEG_D: return 5'h1D;
            SEG_E: return 5'h1E;
            SEG_F: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction
endpackage

// File: rtl/seg7_code_to_nibble.sv
// seg7_code_to_nibble: combinational inverse lookup from active-low segment code to hex nibble
module seg7_code_to_nibble
    import seg7_pkg::*;
(
    input  logic [0:6] code,
    output logic [3:0] nibble,
    output logic       valid
);
    assign {valid, nibble} = seg7_to_nibble(code);
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: samples a multiplexed 7-segment bus and recovers the displayed hex word
// SEG7_DP_CAPTURE_EN adds decimal-point capture (seg_dp input, dp_out output)
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int STABLE_CNT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [0:6]              seg_in,
`ifdef SEG7_DP_CAPTURE_EN
    input  logic                    seg_dp,
    output logic [NUM_DIGITS-1:0]   dp_out,
`endif
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] word_out,
    output logic                    word_valid,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_err
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(STABLE_CNT + 1);
`ifdef SEG7_DP_CAPTURE_EN
    localparam int SW = 8;
`else
    localparam int SW = 7;
`endif
    logic [SW-1:0] pin_smp, s1_smp, s_smp, prev_smp;
    logic [NUM_DIGITS-1:0] s1_sel, s_sel, prev_sel, seen, seen_n, idx_bit;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt, cnt_n;
    scan_state_t state, state_n;
    logic vld, same, cap, nib_ok;
    logic [3:0] nib;
    seg7_code_t s_seg;
    logic [NUM_DIGITS-1:0][3:0] shadow, shadow_n;
    logic [NUM_DIGITS-1:0] shadow_err, shadow_err_n;
`ifdef SEG7_DP_CAPTURE_EN
    logic [NUM_DIGITS-1:0] shadow_dp, shadow_dp_n;
    assign pin_smp = {seg_dp, seg_in};
`else
    assign pin_smp = seg_in;
`endif
    assign s_seg = s_smp[6:0];
    // the decimal point rides in the sample word so it takes part in the stability compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_smp <= '1;
            s_smp <= '1;
            prev_smp <= '1;
            s1_sel <= '1;
            s_sel <= '1;
            prev_sel <= '1;
        end else begin
            s1_smp <= pin_smp;
            s_smp <= s1_smp;
            prev_smp <= s_smp;
            s1_sel <= digit_sel;
            s_sel <= s1_sel;
            prev_sel <= s_sel;
        end
    end
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (!s_sel[i]) idx = IW'(i);
    end
    assign vld = $countones(~s_sel) == 1;
    assign same = (s_sel == prev_sel) && (s_smp == prev_smp);
    assign idx_bit = NUM_DIGITS'(1) << idx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
        end
    end
    // a held captured sample stays put; any other valid sample either extends or restarts the run
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        cap = 1'b0;
        if (!vld) begin
            state_n = IDLE;
            cnt_n = '0;
        end else if (!(state == CAPTURED && same)) begin
            cnt_n = (state == TRACK && same) ? cnt + 1'b1 : CW'(1);
            cap = cnt_n == CW'(STABLE_CNT);
            state_n = cap ? CAPTURED : TRACK;
        end
    end
    seg7_code_to_nibble u_dec (.code(s_seg), .nibble(nib), .valid(nib_ok));
    always_comb begin
        shadow_n = shadow;
        shadow_err_n = shadow_err;
        shadow_n[idx] = nib;
        shadow_err_n[idx] = ~nib_ok;
        seen_n = seen | idx_bit;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen <= '0;
            shadow <= '0;
            shadow_err <= '0;
            word_out <= '0;
            digit_err <= '0;
            word_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_err <= 1'b0;
            if (cap) begin
                shadow <= shadow_n;
                shadow_err <= shadow_err_n;
                if (seen[idx]) begin
                    seen <= idx_bit;
                    frame_err <= 1'b1;
                end else if (&seen_n) begin
                    seen <= '0;
                    word_out <= shadow_n;
                    digit_err <= shadow_err_n;
                    word_valid <= 1'b1;
                end else
                    seen <= seen_n;
            end
        end
    end
`ifdef SEG7_DP_CAPTURE_EN
    always_comb begin
        shadow_dp_n = shadow_dp;
        shadow_dp_n[idx] = ~s_smp[7];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_dp <= '0;
            dp_out <= '0;
        end else if (cap) begin
            shadow_dp <= shadow_dp_n;
            if (!seen[idx] && &seen_n) dp_out <= shadow_dp_n;
        end
    end
`endif
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: vector table, directed corner cases and randomized scans against a frame-level model
module tb_seg7_scan_decoder;
    localparam int N = 8;
    localparam int SC = 4;
    localparam logic [6:0] HEX [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100,
        7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [0:6] seg_in = 7'h7F;
    logic [N-1:0] digit_sel = '1;
    logic [4*N-1:0] word_out;
    logic word_valid;
    logic [N-1:0] digit_err;
    logic frame_err;
    int errors = 0;
    int checks = 0;
    int wv_cnt = 0;
    int fe_cnt = 0;
    typedef struct {
        logic [31:0] word;
        logic [7:0]  err;
        logic        wv;
        logic        fe;
    } exp_t;
    typedef struct {
        logic [31:0] disp;
        logic [7:0]  bad;
        logic [6:0]  bad_code;
        logic [31:0] exp_word;
        logic [7:0]  exp_err;
    } vec_t;
    exp_t d1, d2;
    logic [7:0] m_sel, m_seen, m_er, m_derr;
    logic [6:0] m_seg;
    logic [31:0] m_sh, m_word;
    int m_run;
    vec_t vt [5];
    logic [7:0] r_sel;
    logic [6:0] r_code;
    int r, lat;

    seg7_scan_decoder #(.NUM_DIGITS(N), .STABLE_CNT(SC)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit_sel(digit_sel),
        .word_out(word_out), .word_valid(word_valid), .digit_err(digit_err), .frame_err(frame_err));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] decode(input logic [6:0] code);
        for (int n = 0; n < 16; n++)
            if (HEX[n] == code) return {1'b1, 4'(n)};
        return 5'b0;
    endfunction

    task automatic model_reset();
        m_sel = '1;
        m_seg = '1;
        m_run = 0;
        m_seen = '0;
        m_sh = '0;
        m_er = '0;
        m_word = '0;
        m_derr = '0;
        d1 = '{32'h0, 8'h0, 1'b0, 1'b0};
        d2 = '{32'h0, 8'h0, 1'b0, 1'b0};
    endtask

    // one clock of pin activity; outputs are compared two clocks behind the model (input synchronizer)
    task automatic step(input logic [7:0] sel, input logic [6:0] code);
        exp_t cur;
        int idx;
        logic [4:0] dec;
        digit_sel = sel;
        seg_in = code;
        m_run = (sel == m_sel && code == m_seg) ? m_run + 1 : 1;
        m_sel = sel;
        m_seg = code;
        cur = '{m_word, m_derr, 1'b0, 1'b0};
        if ($countones(~sel) == 1 && m_run == SC) begin
            idx = 0;
            for (int i = 0; i < N; i++)
                if (!sel[i]) idx = i;
            dec = decode(code);
            if (m_seen[idx]) begin
                cur.fe = 1'b1;
                m_seen = '0;
            end
            m_seen[idx] = 1'b1;
            m_sh[4*idx +: 4] = dec[3:0];
            m_er[idx] = ~dec[4];
            if (&m_seen) begin
                m_word = m_sh;
                m_derr = m_er;
                m_seen = '0;
                cur.wv = 1'b1;
            end
            cur.word = m_word;
            cur.err = m_derr;
        end
        @(posedge clk);
        #1;
        check("word_out", word_out, d2.word);
        check("digit_err", 32'(digit_err), 32'(d2.err));
        check("word_valid", 32'(word_valid), 32'(d2.wv));
        check("frame_err", 32'(frame_err), 32'(d2.fe));
        if (word_valid) wv_cnt++;
        if (frame_err) fe_cnt++;
        d2 = d1;
        d1 = cur;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst word_out", word_out, 32'h0);
        check("rst digit_err", 32'(digit_err), 32'h0);
        check("rst word_valid", 32'(word_valid), 32'h0);
        check("rst frame_err", 32'(frame_err), 32'h0);
        digit_sel = '1;
        seg_in = 7'h7F;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic scan(input logic [31:0] w, input logic [7:0] bad, input logic [6:0] bad_code, input int hold);
        for (int d = 0; d < N; d++)
            repeat (hold) step(~(8'(1) << d), bad[d] ? bad_code : HEX[w[4*d +: 4]]);
    endtask

    initial begin
        vt[0] = '{32'h1234ABCD, 8'h00, 7'h7F, 32'h1234ABCD, 8'h00};
        vt[1] = '{32'hFFFFFFFF, 8'h00, 7'h7F, 32'hFFFFFFFF, 8'h00};
        vt[2] = '{32'h00000000, 8'h00, 7'h7F, 32'h00000000, 8'h00};
        vt[3] = '{32'h99999999, 8'h04, 7'b1111110, 32'h99999099, 8'h04};
        vt[4] = '{32'h5E6F7081, 8'h80, 7'b1111111, 32'h0E6F7081, 8'h80};
        model_reset();
        @(negedge clk);
        do_reset();
        repeat (3) step(8'hFF, 7'h7F);
        for (int v = 0; v < 5; v++) begin
            wv_cnt = 0;
            fe_cnt = 0;
            scan(vt[v].disp, vt[v].bad, vt[v].bad_code, 10);
            check("table word", word_out, vt[v].exp_word);
            check("table err", 32'(digit_err), 32'(vt[v].exp_err));
            check("table wv count", 32'(wv_cnt), 32'd1);
            check("table fe count", 32'(fe_cnt), 32'd0);
        end
        // reset in the middle of a frame
        for (int d = 0; d < 4; d++) repeat (10) step(~(8'(1) << d), HEX[d]);
        do_reset();
        wv_cnt = 0;
        fe_cnt = 0;
        scan(32'h00000001, 8'h00, 7'h7F, 10);
        check("post-reset word", word_out, 32'h00000001);
        check("post-reset wv count", 32'(wv_cnt), 32'd1);
        // strobe-to-word_valid latency of the final digit
        do_reset();
        for (int d = 0; d < 7; d++) repeat (10) step(~(8'(1) << d), HEX[d]);
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            step(8'h7F, HEX[7]);
            if (word_valid) lat = k;
        end
        check("latency", 32'(lat), 32'(2 + SC));
        repeat (4) step(8'h7F, HEX[7]);
        // glitch shorter than the stability window
        do_reset();
        wv_cnt = 0;
        fe_cnt = 0;
        repeat (SC - 1) step(8'hDF, HEX[3]);
        scan(32'hFFFFFFFF, 8'h00, 7'h7F, 10);
        check("glitch word", word_out, 32'hFFFFFFFF);
        check("glitch wv count", 32'(wv_cnt), 32'd1);
        check("glitch fe count", 32'(fe_cnt), 32'd0);
        // repeated digit restarts the frame
        do_reset();
        wv_cnt = 0;
        fe_cnt = 0;
        repeat (10) step(8'hFE, HEX[0]);
        repeat (10) step(8'hFD, HEX[5]);
        repeat (10) step(8'hFB, HEX[2]);
        repeat (10) step(8'hFD, HEX[7]);
        check("repeat fe count", 32'(fe_cnt), 32'd1);
        check("repeat wv early", 32'(wv_cnt), 32'd0);
        for (int d = 0; d < 7; d++)
            if (d != 1) repeat (10) step(~(8'(1) << d), HEX[d]);
        check("repeat wv before last", 32'(wv_cnt), 32'd0);
        repeat (10) step(8'h7F, HEX[7]);
        check("repeat wv count", 32'(wv_cnt), 32'd1);
        check("repeat word", word_out, 32'h76543270);
        check("repeat fe total", 32'(fe_cnt), 32'd1);
        // bus faults: two strobes, no strobe
        do_reset();
        wv_cnt = 0;
        fe_cnt = 0;
        repeat (10) step(8'hFC, HEX[1]);
        repeat (10) step(8'hFF, HEX[1]);
        check("fault wv count", 32'(wv_cnt), 32'd0);
        check("fault fe count", 32'(fe_cnt), 32'd0);
        scan(32'h89ABCDEF, 8'h00, 7'h7F, 10);
        check("fault scan word", word_out, 32'h89ABCDEF);
        check("fault scan wv", 32'(wv_cnt), 32'd1);
        check("fault scan fe", 32'(fe_cnt), 32'd0);
        // randomized windows checked cycle by cycle against the model
        for (int w = 0; w < 300; w++) begin
            r = $urandom_range(0, 9);
            r_sel = r < 7 ? ~(8'(1) << (w % 8)) : r < 9 ? ~(8'(1) << $urandom_range(0, 7)) : 8'($urandom);
            r_code = $urandom_range(0, 4) == 0 ? 7'($urandom) : HEX[$urandom_range(0, 15)];
            repeat ($urandom_range(1, 9)) step(r_sel, r_code);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
